bp_reg_map: RTL
===============

// Module: bp_reg_map
// PURPOSE
//  Parametrised BytePipe register map, the next generation of the correlator register block.
//  - Sits above the USB BytePipe and unpacks a 7-bit address space into ports:
//    N_RW read/write regs, N_RO read-only inputs and N_FIFO pop-on-read channels.
//  - Adds burst writes, optional address auto-increment, write strobes and per-channel FIFO reads.
// PARAMETERS
//  N_FIFO    1   number of pop-on-read FIFO channels (>=1)
//  N_RO      4   number of read-only 8b input bytes (>=1)
//  N_RW      4   number of RW registers (>=1)
//  RW_W      8   width of each RW register, 1..8
//  RW_RESET  '0  reset value of all RW regs, flattened, N_RW*RW_W bits
//  Constraint: 2+N_FIFO+N_RO+N_RW <= 127.
// PORTS
//  i_clk         in   1            clock
//  i_rst_n       in   1            reset, asynchronous, active-low
//  o_rw          out  N_RW*RW_W    RW register values, reg i at [i*RW_W +: RW_W]
//  o_rwStrobe    out  N_RW         1-cycle pulse when reg i is written
//  i_ro          in   N_RO*8       read-only bytes
//  i_fifo_data   in   N_FIFO*8     head byte per FIFO channel
//  i_fifo_empty  in   N_FIFO       channel empty (!valid)
//  o_fifo_pop    out  N_FIFO       pop (ready), 1 cycle per byte consumed
//  i_bp_data     in   8            upstream byte
//  i_bp_valid    in   1            upstream valid
//  o_bp_ready    out  1            upstream ready
//  o_bp_data     out  8            response byte, registered
//  o_bp_valid    out  1            response valid
//  i_bp_ready    in   1            downstream ready
// BEHAVIOUR
//  Address map
//   - 0: BURST, 8b burst count.
//   - 1: CTRL, bit0 = autoInc; other bits read 0.
//   - 2..: FIFO channels, then RO bytes, then RW regs.
//   - Above the last mapped address: reads return 0x00, writes are ignored.
//  Reset (async, i_rst_n=0)
//   - State returns to IDLE; BURST=0, CTRL=0, o_rw=RW_RESET.
//   - o_rwStrobe=0, o_fifo_pop=0, o_bp_valid=0, o_bp_data=0x00.
//   - This applies immediately, including mid-transaction. o_bp_ready=1 after reset.
//  Command byte: bit7=1 write, bit7=0 read; [6:0]=addr.
//  Length: len = (BURST>1 && addr!=0) ? BURST : 1.
//  FSM: IDLE -> WDAT (writes) or RLOAD (reads); WDAT -> RLOAD; RLOAD -> RSEND; RSEND -> RLOAD or IDLE.
//   - IDLE: o_bp_ready=1. On accept, latch addr and len; a write goes to WDAT, a read goes to RLOAD.
//   - WDAT: o_bp_ready=1. Each accepted byte is written at addr.
//     - RW reg: RW_W LSBs are taken; o_rwStrobe[i] is high the following cycle, together with the new o_rw.
//     - FIFO or RO address: the write is ignored.
//     - The count decrements. While the count is >0 the FSM stays in WDAT; otherwise it goes to RLOAD with count=0.
//     - Address step: if autoInc, addr+1, saturating at 7'h7F.
//     - Readback: exactly one byte, from the last written address.
//   - RLOAD: o_bp_ready=0. The read mux selects addr.
//     - FIFO channel with empty=1: wait in RLOAD with no pop and no timeout.
//     - Otherwise capture into o_bp_data and go to RSEND. For a FIFO address, pulse o_fifo_pop[ch] in that same cycle.
//   - RSEND: o_bp_valid=1, o_bp_ready=0. o_bp_data stays stable until i_bp_ready.
//     - On accept with remaining read count >0: decrement, step addr (autoInc), go to RLOAD.
//     - Otherwise go to IDLE.
//  Burst rules
//   - BURST auto-clears to 0 at the end of any transaction that used len>1.
//   - Commands to addr 0 ignore BURST; a write there sets it and reads back the new value.
//   - A burst is N bytes in or N bytes out.
//  Latency and throughput
//   - Read cmd accepted -> o_bp_valid in 2 cycles.
//   - Burst reads: 1 byte per 2 cycles when unstalled.
//   - Single write: data accepted -> readback valid in 2 cycles.
// STRUCTURE
//  - Package bp_pkg: ADDR_BURST=0, ADDR_CTRL=1, ADDR_FIFO_LO=2; BP_CMD_WR_BIT=7; state enum {IDLE,WDAT,RLOAD,RSEND}.
//  - Sub-module bp_reg_rdmux: combinational addr -> {byte, isFifo, fifoIdx}. Instantiated once.
//  - Top holds the FSM, counters and register storage.
// TESTING (N_FIFO=1,N_RO=4,N_RW=4,RW_W=8; FIFO@2, RO@3..6, RW@7..10)
//  1. Release reset -> o_rw=RW_RESET, o_bp_valid=0, o_bp_ready=1, pops 0.
//  2. Send 0x87,0x5A -> o_rw[7:0]=0x5A, o_rwStrobe=4'b0001 for 1 cycle, response 0x5A.
//  3. Send 0x81,0x01 (resp 0x01), 0x80,0x04 (resp 0x04), 0x03 with i_ro=0x44332211
//     -> response 0x11,0x22,0x33,0x44; then 0x00 reads 0x00.
//  4. Read 0x02 with empty=1 for 10 cycles -> no valid, no pop, ready=0;
//     then empty=0, data=0xC3 -> pop 1 cycle, response 0xC3.
//  5. Burst read 3 bytes from FIFO, i_bp_ready low 5 cycles mid-burst
//     -> o_bp_data held, exactly 3 pops total.
//  6. Assert i_rst_n=0 mid burst write (after 2 of 4 bytes)
//     -> immediate IDLE, o_rw=RW_RESET, BURST=0, next cmd handled normally.

Source files
------------

// File: rtl/bp_reg_map_pkg.sv
// bp_pkg: shared address map constants, FSM state type and sizing helper for the BytePipe register map.
package bp_pkg;
    localparam logic [6:0] ADDR_BURST   = 7'd0;
    localparam logic [6:0] ADDR_CTRL    = 7'd1;
    localparam logic [6:0] ADDR_FIFO_LO = 7'd2;
    localparam int BP_CMD_WR_BIT = 7;
    typedef enum logic [1:0] {IDLE, WDAT, RLOAD, RSEND} bpState_t;
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/bp_reg_rdmux.sv
// bp_reg_rdmux: combinational address decode to read byte, plus which FIFO channel (if any) the address hits.
module bp_reg_rdmux
    import bp_pkg::*;
#(
    parameter int N_FIFO = 1,
    parameter int N_RO   = 4,
    parameter int N_RW   = 4,
    parameter int RW_W   = 8,
    parameter int FI_W   = 1
) (
    input  logic [6:0]           addr,
    input  logic [7:0]           burst,
    input  logic                 autoInc,
    input  logic [N_FIFO*8-1:0]  fifoData,
    input  logic [N_RO*8-1:0]    ro,
    input  logic [N_RW*RW_W-1:0] rw,
    output logic [7:0]           rdByte,
    output logic                 isFifo,
    output logic [FI_W-1:0]      fifoIdx
);
    localparam int RO_LO = int'(ADDR_FIFO_LO) + N_FIFO;
    localparam int RW_LO = RO_LO + N_RO;

    always_comb begin
        rdByte  = 8'h00;
        isFifo  = 1'b0;
        fifoIdx = '0;
        if (addr == ADDR_BURST) rdByte = burst;
        if (addr == ADDR_CTRL) rdByte = {7'b0, autoInc};
        for (int i = 0; i < N_FIFO; i++) begin
            if (addr == 7'(int'(ADDR_FIFO_LO) + i)) begin
                rdByte  = fifoData[i*8 +: 8];
                isFifo  = 1'b1;
                fifoIdx = FI_W'(i);
            end
        end
        for (int i = 0; i < N_RO; i++) begin
            if (addr == 7'(RO_LO + i)) rdByte = ro[i*8 +: 8];
        end
        // narrow RW registers read back zero-extended
        for (int i = 0; i < N_RW; i++) begin
            if (addr == 7'(RW_LO + i)) rdByte = 8'(rw[i*RW_W +: RW_W]);
        end
    end
endmodule

// File: rtl/bp_reg_map.sv
// bp_reg_map: BytePipe command decoder driving RW registers, RO inputs and pop-on-read FIFO channels,
// with burst transfers and optional address auto-increment.
module bp_reg_map
    import bp_pkg::*;
#(
    parameter int N_FIFO = 1,
    parameter int N_RO   = 4,
    parameter int N_RW   = 4,
    parameter int RW_W   = 8,
    parameter logic [N_RW*RW_W-1:0] RW_RESET = '0
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    output logic [N_RW*RW_W-1:0] o_rw,
    output logic [N_RW-1:0]      o_rwStrobe,
    input  logic [N_RO*8-1:0]    i_ro,
    input  logic [N_FIFO*8-1:0]  i_fifo_data,
    input  logic [N_FIFO-1:0]    i_fifo_empty,
    output logic [N_FIFO-1:0]    o_fifo_pop,
    input  logic [7:0]           i_bp_data,
    input  logic                 i_bp_valid,
    output logic                 o_bp_ready,
    output logic [7:0]           o_bp_data,
    output logic                 o_bp_valid,
    input  logic                 i_bp_ready
);
    localparam int FI_W  = idxWidth(N_FIFO);
    localparam int RW_LO = int'(ADDR_FIFO_LO) + N_FIFO + N_RO;

    bpState_t state, stateNext;
    logic [6:0] addr, addrStep;
    logic [7:0] cnt, burst, cmdLen, rdByte;
    logic autoInc, longTx, accept, canLoad, more, isFifo;
    logic [FI_W-1:0] fifoIdx;
    logic [N_FIFO-1:0] fifoSel;

    bp_reg_rdmux #(
        .N_FIFO(N_FIFO), .N_RO(N_RO), .N_RW(N_RW), .RW_W(RW_W), .FI_W(FI_W)
    ) uRdMux (
        .addr(addr), .burst(burst), .autoInc(autoInc), .fifoData(i_fifo_data),
        .ro(i_ro), .rw(o_rw), .rdByte(rdByte), .isFifo(isFifo), .fifoIdx(fifoIdx)
    );

    always_comb begin
        for (int i = 0; i < N_FIFO; i++) fifoSel[i] = isFifo && (fifoIdx == FI_W'(i));
    end

    assign o_bp_ready = (state == IDLE) || (state == WDAT);
    assign o_bp_valid = state == RSEND;
    assign accept     = i_bp_valid && o_bp_ready;
    assign canLoad    = ~|(fifoSel & i_fifo_empty);
    assign o_fifo_pop = (state == RLOAD) ? (fifoSel & ~i_fifo_empty) : '0;
    // cnt holds the bytes still owed in the current transaction, including the one in flight
    assign more       = cnt > 8'd1;
    assign addrStep   = (autoInc && addr != 7'h7F) ? addr + 7'd1 : addr;
    assign cmdLen     = (burst > 8'd1 && i_bp_data[6:0] != ADDR_BURST) ? burst : 8'd1;

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (accept) stateNext = i_bp_data[BP_CMD_WR_BIT] ? WDAT : RLOAD;
            WDAT:    if (accept && !more) stateNext = RLOAD;
            RLOAD:   if (canLoad) stateNext = RSEND;
            RSEND:   if (i_bp_ready) stateNext = more ? RLOAD : IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else state <= stateNext;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            addr       <= '0;
            cnt        <= '0;
            burst      <= '0;
            autoInc    <= 1'b0;
            longTx     <= 1'b0;
            o_rw       <= RW_RESET;
            o_rwStrobe <= '0;
            o_bp_data  <= '0;
        end else begin
            o_rwStrobe <= '0;
            case (state)
                IDLE: if (accept) begin
                    addr   <= i_bp_data[6:0];
                    cnt    <= cmdLen;
                    longTx <= cmdLen > 8'd1;
                end
                WDAT: if (accept) begin
                    if (addr == ADDR_BURST) burst <= i_bp_data;
                    if (addr == ADDR_CTRL) autoInc <= i_bp_data[0];
                    for (int i = 0; i < N_RW; i++) begin
                        if (addr == 7'(RW_LO + i)) begin
                            o_rw[i*RW_W +: RW_W] <= i_bp_data[RW_W-1:0];
                            o_rwStrobe[i]        <= 1'b1;
                        end
                    end
                    cnt <= more ? cnt - 8'd1 : 8'd0;
                    if (more) addr <= addrStep;
                end
                RLOAD: if (canLoad) o_bp_data <= rdByte;
                RSEND: if (i_bp_ready) begin
                    if (more) begin
                        cnt  <= cnt - 8'd1;
                        addr <= addrStep;
                    end else if (longTx) begin
                        burst  <= '0;
                        longTx <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
